// File: rtl/sd_defines.sv
// Shared encodings for the SD controller Wishbone DMA arbiter: policies, FSM states, cycle types.
package sd_defines;

    localparam int ARB_RR = 0;
    localparam int ARB_P0 = 1;
    localparam int ARB_P1 = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_G0    = 2'd1,
        ST_G1    = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/sd_wb_watchdog.sv
// Counts owner-stb cycles without ack/err; expired is combinational in the threshold cycle.
// No flow control of its own; cleared whenever the bus is idle, stb is low or a termination arrives.
module sd_wb_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stb,
    input  logic term,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!active || !stb || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A termination in the threshold cycle wins over the abort.
    assign expired = (TIMEOUT != 0) && active && stb && !term
                     && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/sd_wb_master_arbiter.sv
// Two-port Wishbone master arbiter: registered grant (one cycle from cyc), combinational bus mux and return path.
// Losers wait with signals held and are never acked; a watchdog aborts stalled cycles with err + one ABORT cycle.
module sd_wb_master_arbiter
    import sd_defines::*;
#(
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 1024,
    parameter int TO_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_t state, next_state;
    logic       last_grant;
    logic       both_pick_g1;
    logic       owner_active;
    logic       owner_stb;
    logic       wd_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_G0) last_grant <= 1'b0;
            if (state == ST_IDLE && next_state == ST_G1) last_grant <= 1'b1;
        end
    end

    always_comb begin
        case (PRIORITY)
            ARB_P0:  both_pick_g1 = 1'b0;
            ARB_P1:  both_pick_g1 = 1'b1;
            default: both_pick_g1 = !last_grant;
        endcase
    end

    assign owner_active = (state == ST_G0) || (state == ST_G1);
    assign owner_stb    = (state == ST_G0) ? m0_stb_i :
                          (state == ST_G1) ? m1_stb_i : 1'b0;

    sd_wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (owner_active),
        .stb     (owner_stb),
        .term    (m_wb_ack_i | m_wb_err_i),
        .expired (wd_expired)
    );

    always_comb begin
        next_state = state;
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        m_wb_cti_o = '0;
        m_wb_bte_o = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) next_state = both_pick_g1 ? ST_G1 : ST_G0;
                else if (m0_cyc_i)        next_state = ST_G0;
                else if (m1_cyc_i)        next_state = ST_G1;
            end
            ST_G0: begin
                m_wb_adr_o = m0_adr_i;
                m_wb_dat_o = m0_dat_i;
                m_wb_we_o  = m0_we_i;
                m_wb_cyc_o = m0_cyc_i;
                m_wb_stb_o = m0_stb_i;
                m_wb_cti_o = m0_cti_i;
                m_wb_bte_o = m0_bte_i;
                m0_ack_o   = m_wb_ack_i & m0_stb_i;
                m0_err_o   = (m_wb_err_i & m0_stb_i) | wd_expired;
                if (wd_expired)     next_state = ST_ABORT;
                else if (!m0_cyc_i) next_state = ST_IDLE;
            end
            ST_G1: begin
                m_wb_adr_o = m1_adr_i;
                m_wb_dat_o = m1_dat_i;
                m_wb_we_o  = m1_we_i;
                m_wb_cyc_o = m1_cyc_i;
                m_wb_stb_o = m1_stb_i;
                m_wb_cti_o = m1_cti_i;
                m_wb_bte_o = m1_bte_i;
                m1_ack_o   = m_wb_ack_i & m1_stb_i;
                m1_err_o   = (m_wb_err_i & m1_stb_i) | wd_expired;
                if (wd_expired)     next_state = ST_ABORT;
                else if (!m1_cyc_i) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign m0_dat_o  = m_wb_dat_i;
    assign m1_dat_o  = m_wb_dat_i;
    assign grant_o   = {state == ST_G1, state == ST_G0};
    assign timeout_o = wd_expired;

endmodule

// File: tb/tb_sd_wb_master_arbiter.sv
// Directed bench: dut_a is round-robin, dut_b fixed port-0 priority; both TIMEOUT=16 and share all inputs.
module tb_sd_wb_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, m_wb_dat_i;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, m_wb_ack_i, m_wb_err_i;
    logic [2:0]  m0_cti, m1_cti;
    logic [1:0]  m0_bte, m1_bte;

    logic [31:0] a_m0_dat, a_m1_dat, a_adr, a_dat, b_m0_dat, b_m1_dat, b_adr, b_dat;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_we, a_cyc, a_stb, a_to;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_we, b_cyc, b_stb, b_to;
    logic [2:0]  a_cti, b_cti;
    logic [1:0]  a_bte, b_bte, a_grant, b_grant;

    sd_wb_master_arbiter #(.PRIORITY(0), .TIMEOUT(16), .TO_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
        .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
        .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .m_wb_adr_o(a_adr), .m_wb_dat_o(a_dat), .m_wb_we_o(a_we), .m_wb_cyc_o(a_cyc),
        .m_wb_stb_o(a_stb), .m_wb_cti_o(a_cti), .m_wb_bte_o(a_bte),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
        .grant_o(a_grant), .timeout_o(a_to)
    );

    sd_wb_master_arbiter #(.PRIORITY(1), .TIMEOUT(16), .TO_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
        .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
        .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .m_wb_adr_o(b_adr), .m_wb_dat_o(b_dat), .m_wb_we_o(b_we), .m_wb_cyc_o(b_cyc),
        .m_wb_stb_o(b_stb), .m_wb_cti_o(b_cti), .m_wb_bte_o(b_bte),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
        .grant_o(b_grant), .timeout_o(b_to)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic       early;
    int         w;
    logic [1:0] exp_g;

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0; m0_cti = '0; m0_bte = '0;
        m1_adr = '0; m1_dat = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0; m1_cti = '0; m1_bte = '0;
        m_wb_dat_i = 32'h55AA_1234; m_wb_ack_i = 0; m_wb_err_i = 0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_grant", a_grant, 2'b00);
        chk("rst_cyc", a_cyc, 1'b0);
        chk("rst_adr", a_adr, 32'h0);
        chk("rst_timeout", a_to, 1'b0);
        chk("rst_ack", a_m0_ack, 1'b0);
        chk("rst_dat0", a_m0_dat, 32'h55AA_1234);
        chk("rst_dat1", a_m1_dat, 32'h55AA_1234);

        // Port 0 single write, slave acks two cycles after stb reaches the bus.
        step(); rst = 1'b0;
        step(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h1000; m0_dat = 32'hDEAD_BEEF;
        mid();  chk("w_grant_early", a_grant, 2'b00); chk("w_cyc_early", a_cyc, 1'b0);
        step(); mid();
        chk("w_grant", a_grant, 2'b01);
        chk("w_adr", a_adr, 32'h1000);
        chk("w_dat", a_dat, 32'hDEAD_BEEF);
        chk("w_we", a_we, 1'b1);
        chk("w_stb", a_stb, 1'b1);
        step(); mid(); chk("w_ack_pre", a_m0_ack, 1'b0);
        step(); m_wb_ack_i = 1; mid(); chk("w_ack", a_m0_ack, 1'b1); chk("w_ack_m1", a_m1_ack, 1'b0);
        step(); m_wb_ack_i = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        mid();  chk("w_ack_post", a_m0_ack, 1'b0); chk("w_bus_cyc_drop", a_cyc, 1'b0);
        step(); mid(); chk("w_release", a_grant, 2'b00);

        // Round-robin: both request together, 4 back-to-back beats each, three rounds.
        step(); rst = 1'b1; step(); rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            step(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m1_cyc = 1; m1_stb = 1; m1_we = 0;
            for (int k = 0; k < 2; k++) begin
                exp_g = (k == 0) ? 2'b01 : 2'b10;
                w = 0;
                do begin step(); mid(); w++; end while (a_grant == 2'b00 && w < 8);
                chk("rr_grant", a_grant, exp_g);
                for (int b = 0; b < 4; b++) begin
                    m_wb_ack_i = 1; #1;
                    chk("rr_ack_own", (k == 0) ? a_m0_ack : a_m1_ack, 1'b1);
                    chk("rr_ack_other", (k == 0) ? a_m1_ack : a_m0_ack, 1'b0);
                    step(); m_wb_ack_i = 0;
                    if (b == 3) begin
                        if (k == 0) begin m0_cyc = 0; m0_stb = 0; end
                        else        begin m1_cyc = 0; m1_stb = 0; end
                    end
                    mid();
                end
                step(); mid(); chk("rr_gap", a_grant, 2'b00);
            end
        end

        // dut_b: port 1 8-beat incrementing burst, port 0 requests mid-burst.
        step(); m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h2000; m1_cti = 3'b010;
        step(); mid(); chk("p1_grant1", b_grant, 2'b10);
        for (int b = 0; b < 8; b++) begin
            m1_cti = (b == 7) ? 3'b111 : 3'b010;
            m1_adr = 32'h2000 + b * 4;
            if (b == 2) begin m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h5000; end
            m_wb_ack_i = 1; #1;
            chk("p1_burst_ack", b_m1_ack, 1'b1);
            chk("p1_burst_m0_ack", b_m0_ack, 1'b0);
            chk("p1_hold", b_grant, 2'b10);
            chk("p1_cti", b_cti, (b == 7) ? 3'd7 : 3'd2);
            step(); m_wb_ack_i = 0;
            if (b == 7) begin m1_cyc = 0; m1_stb = 0; m1_cti = 3'b000; end
            mid();
        end
        step(); mid(); chk("p1_gap", b_grant, 2'b00);
        step(); mid(); chk("p1_grant0", b_grant, 2'b01); chk("p1_adr0", b_adr, 32'h5000);
        m_wb_ack_i = 1; #1; chk("p1_ack0", b_m0_ack, 1'b1);
        step(); m_wb_ack_i = 0; m0_cyc = 0; m0_stb = 0;
        step(); step(); mid(); chk("p1_idle", b_grant, 2'b00);
        // Tie with last owner = port 0: fixed priority keeps port 0, round-robin moves to port 1.
        step(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        step(); mid(); chk("tie_p0_prio", b_grant, 2'b01); chk("tie_rr", a_grant, 2'b10);
        step(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        step(); step(); mid(); chk("tie_idle", a_grant, 2'b00);

        // Watchdog: port 1 read never acked.
        step(); m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h3000;
        early = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step(); mid();
            if (a_to || a_m1_err) early = 1'b1;
        end
        chk("wd_early", early, 1'b0);
        step(); mid();
        chk("wd_err", a_m1_err, 1'b1);
        chk("wd_pulse", a_to, 1'b1);
        chk("wd_cyc_hold", a_cyc, 1'b1);
        step(); mid();
        chk("wd_abort_cyc", a_cyc, 1'b0);
        chk("wd_abort_stb", a_stb, 1'b0);
        chk("wd_abort_grant", a_grant, 2'b00);
        chk("wd_abort_to", a_to, 1'b0);
        m_wb_ack_i = 1; #1; chk("wd_late_ack_abort", a_m1_ack, 1'b0);
        step(); mid(); chk("wd_late_ack_idle", a_m1_ack, 1'b0); chk("wd_idle", a_grant, 2'b00);
        m_wb_ack_i = 0;
        step(); mid(); chk("wd_regrant", a_grant, 2'b10);
        step(); m1_cyc = 0; m1_stb = 0;
        step(); step();

        // Ack exactly in the threshold cycle beats the watchdog.
        step(); m1_cyc = 1; m1_stb = 1;
        for (int c = 1; c <= 15; c++) begin step(); mid(); end
        step(); mid();
        m_wb_ack_i = 1; #1;
        chk("edge_ack", a_m1_ack, 1'b1);
        chk("edge_err", a_m1_err, 1'b0);
        chk("edge_to", a_to, 1'b0);
        step(); m_wb_ack_i = 0; m1_cyc = 0; m1_stb = 0;
        mid();  chk("edge_no_abort", a_grant, 2'b10);
        step(); mid(); chk("edge_release", a_grant, 2'b00);

        // Slave err pass-through, then reset while port 0 owns the bus.
        step(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h4000; m0_dat = 32'hCAFE_0001;
        step(); mid(); chk("pre_rst_grant", a_grant, 2'b01);
        m_wb_err_i = 1; #1;
        chk("err_pass", a_m0_err, 1'b1);
        chk("err_not_m1", a_m1_err, 1'b0);
        m_wb_err_i = 0;
        step(); mid(); chk("err_hold", a_grant, 2'b01);
        rst = 1'b1; #1;
        chk("rst_mid_cyc", a_cyc, 1'b0);
        chk("rst_mid_stb", a_stb, 1'b0);
        chk("rst_mid_we", a_we, 1'b0);
        chk("rst_mid_adr", a_adr, 32'h0);
        chk("rst_mid_dat", a_dat, 32'h0);
        chk("rst_mid_grant", a_grant, 2'b00);
        step(); rst = 1'b0;
        mid();  chk("rst_rel_idle", a_grant, 2'b00);
        step(); mid(); chk("rst_regrant", a_grant, 2'b01);
        step(); m0_cyc = 0; m0_stb = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_wb_master_arbiter.md
Name: sd_wb_master_arbiter

Overview:
- Shares the SD controller's single Wishbone DMA master port between two requesters:
  - port 0: RX filler (memory writes).
  - port 1: TX filler (memory reads).
- Grants one requester at a time and holds the grant for that requester's whole cycle (cyc high).
- Muxes the requester's signals onto the shared bus and routes ack, err and read data back to it.
- A watchdog aborts cycles the slave never acknowledges, so a stuck bus cannot hang a data transfer.

Parameters:
- PRIORITY, 0: arbitration policy. 0 = round-robin, 1 = port 0 always wins, 2 = port 1 always wins.
- TIMEOUT, 1024: cycles of stb without ack/err before the cycle is aborted. Range 2..65535; 0 disables the watchdog.
- TO_W, 16: watchdog counter width.

Ports:
- clk  in  1  system/Wishbone clock
- rst  in  1  asynchronous reset, active-high
- m0_adr_i  in  32  port 0 address
- m0_dat_i  in  32  port 0 write data
- m0_we_i, m0_cyc_i, m0_stb_i  in  1 each  port 0 control
- m0_cti_i  in  3  port 0 cycle type
- m0_bte_i  in  2  port 0 burst type
- m0_dat_o  out  32  port 0 read data
- m0_ack_o, m0_err_o  out  1 each  port 0 termination
- m1_*  same set as m0_*  port 1 (TX filler)
- m_wb_adr_o  out  32  shared bus address
- m_wb_dat_o  out  32  shared bus write data
- m_wb_we_o, m_wb_cyc_o, m_wb_stb_o  out  1 each  shared bus control
- m_wb_cti_o  out  3  shared bus cycle type
- m_wb_bte_o  out  2  shared bus burst type
- m_wb_dat_i  in  32  shared bus read data
- m_wb_ack_i, m_wb_err_i  in  1 each  shared bus termination
- grant_o  out  2  one-hot current owner; 00 = idle
- timeout_o  out  1  one-cycle pulse when the watchdog aborts a cycle

Behaviour:
- Clock/reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state IDLE, grant_o=00, last_grant=port 1 (so port 0 wins the first tie), watchdog counter 0, timeout_o=0.
  - All m_wb_* outputs 0; all mX_ack_o/err_o 0; mX_dat_o follows m_wb_dat_i.
- States:
  - IDLE → G0 when the arbiter picks port 0; IDLE → G1 when it picks port 1.
  - G0 → IDLE when m0_cyc_i=0; G1 → IDLE when m1_cyc_i=0.
  - ABORT → IDLE unconditionally after one cycle.
- Arbitration (in IDLE only, on the cyc inputs):
  - Exactly one requester: grant it.
  - Both requesting: PRIORITY=1 → port 0; PRIORITY=2 → port 1; PRIORITY=0 → the port not in last_grant.
  - last_grant updates on every entry to G0/G1.
- Grant latency: grant is registered. A requester raising cyc in cycle N sees its signals on the bus in cycle N+1 at the earliest. A losing requester waits with its signals held; the arbiter never acks it.
- Bus mux:
  - In G0/G1, all m_wb_* outputs combinationally equal the granted port's inputs.
  - In IDLE/ABORT, m_wb_cyc_o=m_wb_stb_o=m_wb_we_o=0; adr/dat/cti/bte are driven 0.
- Return path:
  - mX_ack_o = m_wb_ack_i & granted(X) & mX_stb_i. mX_err_o follows the same rule with m_wb_err_i.
  - mX_dat_o = m_wb_dat_i for both ports; only the ack qualifies it.
- Grant hold and bursts:
  - The grant persists across back-to-back and burst transfers while cyc stays high, including cti=010 incrementing bursts.
  - Release happens only when the owner drops cyc. The re-arbitration decision is made in the IDLE cycle that follows, so there is at least one idle bus cycle between owners.
- Watchdog:
  - Counter clears on entry to G0/G1, on any ack/err, and whenever the owner's stb is low.
  - Counter increments each cycle the owner's stb is high without ack/err.
  - When it reaches TIMEOUT-1 with still no termination:
    - That cycle: mX_err_o=1 to the owner and timeout_o=1.
    - Next cycle: go to ABORT, with shared cyc/stb forced low.
  - After ABORT the arbiter returns to IDLE. If the owner still holds cyc, it is re-arbitrated normally.
  - A late ack arriving in ABORT or IDLE is discarded; it never reaches either port.
- Simultaneous events:
  - ack in the same cycle as the timeout threshold: ack wins; no err, no timeout_o.
  - Owner drops cyc in the same cycle as ack: the ack is delivered and the state goes to IDLE.
  - err from the slave: passed through; grant is kept until cyc drops.
- Reset mid-cycle: bus outputs go to 0 immediately (asynchronous) and any pending transfer is discarded.

Decomposition:
- Shared package sd_defines: PRIORITY encodings (ARB_RR=0, ARB_P0=1, ARB_P1=2), state encodings, CTI constants (CTI_CLASSIC=3'b000, CTI_INC=3'b010, CTI_END=3'b111).
- Sub-module: sd_wb_watchdog, holding the counter, clear/enable logic and threshold compare, producing a timeout strobe.

Test Plan:
- Reset then port 0 single write (adr=0x1000, dat=0xDEADBEEF; slave acks 2 cycles after stb) → grant_o=01 one cycle after cyc; bus shows 0x1000/0xDEADBEEF, we=1; m0_ack_o for exactly one cycle; grant_o=00 after cyc drops.
- Both ports raise cyc in the same cycle, PRIORITY=0, 4 transfers each, repeated 3 times → grants alternate 01,10,01,10,01,10; never two owners at once; at least one idle cycle between owners.
- PRIORITY=1, port 1 requesting continuously, port 0 requests mid-transfer → port 0 is granted only after port 1 drops cyc; port 1's 8-beat burst (cti=010…111) completes uninterrupted.
- TIMEOUT=16, slave never acks port 1 read → m1_err_o and timeout_o pulse at cycle 16 after stb; m_wb_cyc_o=0 the next cycle; a later ack does not reach m1_ack_o.
- TIMEOUT=16, ack arrives at exactly cycle 16 → m1_ack_o=1, m1_err_o=0, timeout_o=0.
- rst asserted while port 0 owns the bus with stb high → all m_wb_* outputs 0 in the same cycle; grant_o=00; after release, port 0 (cyc still high) is re-granted one cycle later.
